// File: rtl/neopixel_rx.sv
// NeoPixel (WS2812-style) serial receiver.
// Samples din through a two-flop synchronizer and classifies each high
// pulse by its width. A width of T_THRESH cycles or more decodes as 1.
// A shorter pulse decodes as 0, and a pulse below T_MIN is a glitch.
// A low gap of T_RESET cycles ends the frame (latch).
// Ports:
//   clk_20M      : 20 MHz clock, all logic on its rising edge
//   rst          : asynchronous active-high reset
//   din          : asynchronous serial line
//   rx_data      : last decoded byte, MSB received first (held between strobes)
//   rx_valid     : one-cycle strobe, rx_data/rx_index valid
//   rx_index     : byte position in the current frame (held)
//   frame_done   : one-cycle strobe at a latch gap that ends a non-empty frame
//   frame_bytes  : byte count of the ended frame (held)
//   err_glitch   : high pulse shorter than T_MIN
//   err_long     : line stuck high for T_MAXHIGH cycles
//   err_partial  : latch gap arrived with an incomplete byte
//   err_overflow : byte beyond MAX_BYTES dropped
module neopixel_rx #(
  parameter int unsigned T_THRESH  = 12,
  parameter int unsigned T_MIN     = 3,
  parameter int unsigned T_MAXHIGH = 40,
  parameter int unsigned T_RESET   = 1000,
  parameter int unsigned MAX_BYTES = 48
) (
  input  logic       clk_20M,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [5:0] rx_index,
  output logic       frame_done,
  output logic [5:0] frame_bytes,
  output logic       err_glitch,
  output logic       err_long,
  output logic       err_partial,
  output logic       err_overflow
);

  localparam int unsigned LW = $clog2(T_RESET + 1);
  localparam int unsigned HW = $clog2(T_MAXHIGH + 1);

  localparam logic [LW-1:0] LOW_MAX  = LW'(T_RESET);
  localparam logic [LW-1:0] LOW_LAST = LW'(T_RESET - 1);
  localparam logic [HW-1:0] HI_LAST  = HW'(T_MAXHIGH - 1);
  localparam logic [HW-1:0] HI_MIN   = HW'(T_MIN);
  localparam logic [HW-1:0] HI_ONE   = HW'(T_THRESH);
  localparam logic [5:0]    BYTE_MAX = 6'(MAX_BYTES);

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  state_t        state_q, state_d;
  logic          din_m_q, din_m_d, din_s_q, din_s_d, din_d_q, din_d_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic [HW-1:0] high_cnt_q, high_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [5:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [5:0]    rx_index_q, rx_index_d;
  logic [5:0]    frame_bytes_q, frame_bytes_d;
  logic          rx_valid_q, rx_valid_d, frame_done_q, frame_done_d;
  logic          err_glitch_q, err_glitch_d, err_long_q, err_long_d;
  logic          err_partial_q, err_partial_d, err_overflow_q, err_overflow_d;

  logic       rise;
  logic [7:0] shift_new;

  always_comb begin
    din_m_d        = din;
    din_s_d        = din_m_q;
    din_d_d        = din_s_q;
    state_d        = state_q;
    low_cnt_d      = low_cnt_q;
    high_cnt_d     = high_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_index_d     = rx_index_q;
    frame_bytes_d  = frame_bytes_q;
    rx_valid_d     = 1'b0;
    frame_done_d   = 1'b0;
    err_glitch_d   = 1'b0;
    err_long_d     = 1'b0;
    err_partial_d  = 1'b0;
    err_overflow_d = 1'b0;

    rise      = din_s_q & ~din_d_q;
    shift_new = {shift_q[6:0], (high_cnt_q >= HI_ONE)};

    case (state_q)
      // Wait for a full latch gap before trusting the line.
      SYNC: begin
        if (din_s_q) begin
          low_cnt_d = '0;
        end else if (low_cnt_q >= LOW_LAST) begin
          // Enter LOW already saturated so this gap does not end a frame.
          low_cnt_d  = LOW_MAX;
          state_d    = LOW;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end else begin
          low_cnt_d = low_cnt_q + LW'(1);
        end
      end

      LOW: begin
        if (rise) begin
          state_d    = HIGH;
          high_cnt_d = HW'(1);
          low_cnt_d  = '0;
        end else if (low_cnt_q != LOW_MAX) begin
          low_cnt_d = low_cnt_q + LW'(1);
          if (low_cnt_q == LOW_LAST) begin
            if (byte_cnt_q != '0) begin
              frame_done_d  = 1'b1;
              frame_bytes_d = byte_cnt_q;
            end
            if (bit_cnt_q != '0) err_partial_d = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end
        end
      end

      HIGH: begin
        if (din_s_q) begin
          if (high_cnt_q == HI_LAST) begin
            err_long_d = 1'b1;
            state_d    = SYNC;
            low_cnt_d  = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end else begin
            high_cnt_d = high_cnt_q + HW'(1);
          end
        end else begin
          // Falling edge; this low cycle is the first of the gap.
          state_d   = LOW;
          low_cnt_d = LW'(1);
          if (high_cnt_q < HI_MIN) begin
            err_glitch_d = 1'b1;
          end else begin
            shift_d   = shift_new;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (byte_cnt_q < BYTE_MAX) begin
                rx_valid_d = 1'b1;
                rx_data_d  = shift_new;
                rx_index_d = byte_cnt_q;
                byte_cnt_d = byte_cnt_q + 6'd1;
              end else begin
                err_overflow_d = 1'b1;
              end
            end
          end
        end
      end

      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_20M or posedge rst) begin
    if (rst) begin
      state_q        <= SYNC;
      din_m_q        <= 1'b0;
      din_s_q        <= 1'b0;
      din_d_q        <= 1'b0;
      low_cnt_q      <= '0;
      high_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_index_q     <= '0;
      frame_bytes_q  <= '0;
      rx_valid_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      err_glitch_q   <= 1'b0;
      err_long_q     <= 1'b0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      din_m_q        <= din_m_d;
      din_s_q        <= din_s_d;
      din_d_q        <= din_d_d;
      low_cnt_q      <= low_cnt_d;
      high_cnt_q     <= high_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_index_q     <= rx_index_d;
      frame_bytes_q  <= frame_bytes_d;
      rx_valid_q     <= rx_valid_d;
      frame_done_q   <= frame_done_d;
      err_glitch_q   <= err_glitch_d;
      err_long_q     <= err_long_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_index     = rx_index_q;
  assign frame_done   = frame_done_q;
  assign frame_bytes  = frame_bytes_q;
  assign err_glitch   = err_glitch_q;
  assign err_long     = err_long_q;
  assign err_partial  = err_partial_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// Scoreboard bench for neopixel_rx: stimulus pushes expected events into
// per-kind queues and a monitor pops and compares on every strobe.
`timescale 1ns/1ps
module tb_neopixel_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [5:0] rx_index;
  logic       frame_done;
  logic [5:0] frame_bytes;
  logic       err_glitch, err_long, err_partial, err_overflow;

  int checks = 0;
  int failures = 0;

  logic [13:0] exp_rx[$];   // {idx, data}
  logic [5:0]  exp_fd[$];
  logic [1:0]  exp_err[$];  // 0 glitch, 1 long, 2 partial, 3 overflow

  always #25 clk = ~clk;

  neopixel_rx #(
    .T_THRESH (12),
    .T_MIN    (3),
    .T_MAXHIGH(40),
    .T_RESET  (1000),
    .MAX_BYTES(48)
  ) dut (
    .clk_20M     (clk),
    .rst         (rst),
    .din         (din),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_index    (rx_index),
    .frame_done  (frame_done),
    .frame_bytes (frame_bytes),
    .err_glitch  (err_glitch),
    .err_long    (err_long),
    .err_partial (err_partial),
    .err_overflow(err_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_err(input logic [1:0] code);
    logic [1:0] e;
    if (exp_err.size() == 0) begin
      check("unexpected_err", 32'(code), 32'hFF);
    end else begin
      e = exp_err.pop_front();
      check("err_kind", 32'(code), 32'(e));
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("unexpected_rx_valid", {18'd0, rx_index, rx_data}, 32'hFFFF);
        else check("rx_idx_data", {18'd0, rx_index, rx_data}, 32'(exp_rx.pop_front()));
      end
      if (frame_done) begin
        if (exp_fd.size() == 0) check("unexpected_frame_done", 32'(frame_bytes), 32'hFF);
        else check("frame_bytes", 32'(frame_bytes), 32'(exp_fd.pop_front()));
      end
      if (err_glitch)   check_err(2'd0);
      if (err_long)     check_err(2'd1);
      if (err_partial)  check_err(2'd2);
      if (err_overflow) check_err(2'd3);
    end
  end

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_w(input int hi, input int lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_w(16, 9);
    else   send_w(8, 17);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic gap();
    hold(1'b0, 1050);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_index", 32'(rx_index), 32'h0);
    check("rst_frame_bytes", 32'(frame_bytes), 32'h0);
    check("rst_strobes", {26'd0, rx_valid, frame_done, err_glitch, err_long, err_partial, err_overflow}, 32'h0);
    rst = 1'b0;
    gap();

    // Two-byte frame
    exp_rx.push_back({6'd0, 8'hA5});
    exp_rx.push_back({6'd1, 8'h3C});
    send_byte(8'hA5);
    send_byte(8'h3C);
    exp_fd.push_back(6'd2);
    gap();
    check("hold_rx_data", 32'(rx_data), 32'h3C);
    check("hold_rx_index", 32'(rx_index), 32'h1);
    check("hold_frame_bytes", 32'(frame_bytes), 32'h2);

    // Width boundaries, glitch, 1-cycle low times: bits 1010_1110
    exp_err.push_back(2'd0);
    exp_rx.push_back({6'd0, 8'hAE});
    send_w(12, 9); send_w(11, 9); send_w(12, 1); send_w(11, 1);
    send_w(2, 9);
    send_w(12, 9); send_w(12, 1); send_w(12, 1); send_w(11, 9);
    exp_fd.push_back(6'd1);
    gap();

    // Overflow: 49 bytes, 48 accepted
    for (int i = 0; i < 49; i++) begin
      if (i < 48) exp_rx.push_back({6'(i), 8'(i * 37 + 11)});
      else        exp_err.push_back(2'd3);
      send_byte(8'(i * 37 + 11));
    end
    exp_fd.push_back(6'd48);
    gap();
    check("ovf_frame_bytes_hold", 32'(frame_bytes), 32'd48);

    // Partial byte: 5 bits then latch gap
    exp_err.push_back(2'd2);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    gap();

    // Stuck high mid-byte, following bytes ignored until a gap
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    exp_err.push_back(2'd1);
    hold(1'b1, 45);
    hold(1'b0, 9);
    send_byte(8'h81);
    send_byte(8'h7E);
    gap();
    exp_rx.push_back({6'd0, 8'h5A});
    send_byte(8'h5A);
    exp_fd.push_back(6'd1);
    gap();

    // Reset during byte 3, then continue the stream
    exp_rx.push_back({6'd0, 8'h11});
    exp_rx.push_back({6'd1, 8'h22});
    send_byte(8'h11);
    send_byte(8'h22);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    #10 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", 32'(rx_data), 32'h0);
    check("midrst_rx_index", 32'(rx_index), 32'h0);
    rst = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hF0);
    send_byte(8'h0F);
    gap();
    exp_rx.push_back({6'd0, 8'hC3});
    send_byte(8'hC3);
    exp_fd.push_back(6'd1);
    gap();

    repeat (20) @(negedge clk);
    check("pending_rx", 32'(exp_rx.size()), 32'd0);
    check("pending_frame_done", 32'(exp_fd.size()), 32'd0);
    check("pending_err", 32'(exp_err.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neopixel_rx.md
NEOPIXEL_RX -- requirements
Module: neopixel_rx

Interface
REQ-001 Parameter T_THRESH, default 12: high width in clk_20M cycles at or above which a bit decodes as 1 (0.6 us).
REQ-002 Parameter T_MIN, default 3: high widths below this are glitches.
REQ-003 Parameter T_MAXHIGH, default 40: high width at which the line is declared stuck (2.0 us).
REQ-004 Parameter T_RESET, default 1000: continuous low cycles constituting a latch/reset gap (50 us).
REQ-005 Parameter MAX_BYTES, default 48: bytes accepted per frame.
REQ-006 clk_20M  input  1  sole clock, 20 MHz, all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 din  input  1  asynchronous NeoPixel serial line.
REQ-009 rx_data  output  8  last decoded byte, MSB received first.
REQ-010 rx_valid  output  1  one-cycle strobe, rx_data/rx_index valid.
REQ-011 rx_index  output  6  byte position in frame, 0-based.
REQ-012 frame_done  output  1  one-cycle strobe at latch gap ending a frame with at least 1 byte.
REQ-013 frame_bytes  output  6  byte count of frame, valid with frame_done.
REQ-014 err_glitch, err_long, err_partial, err_overflow  output  1 each  one-cycle error strobes.

Function
REQ-015 din SHALL pass through a 2-flop synchronizer (din_s); all timing uses din_s; edges detected against a registered copy of din_s.
REQ-016 States SHALL be SYNC, LOW, HIGH.
REQ-017 SYNC: low_cnt counts consecutive din_s=0 cycles; any din_s=1 clears it; on reaching T_RESET go LOW with bit and byte counters cleared, no strobes.
REQ-018 LOW: low_cnt increments each cycle (saturating at T_RESET); rising edge -> HIGH with high_cnt=1, low_cnt=0.
REQ-019 LOW, low_cnt reaching T_RESET (once per gap): if byte_cnt>0 pulse frame_done with frame_bytes=byte_cnt; if bit_cnt!=0 pulse err_partial and discard partial byte; clear bit_cnt, byte_cnt.
REQ-020 HIGH: high_cnt increments each din_s=1 cycle; on reaching T_MAXHIGH pulse err_long, discard partial byte, clear counters, go SYNC.
REQ-021 HIGH, falling edge with high_cnt<T_MIN: pulse err_glitch, no bit shifted, return LOW.
REQ-022 HIGH, falling edge with high_cnt>=T_MIN: shift in bit (high_cnt>=T_THRESH ? 1 : 0) at LSB of shift register, bit_cnt+1, go LOW.
REQ-023 On 8th bit: if byte_cnt<MAX_BYTES, pulse rx_valid with rx_data=shift value, rx_index=byte_cnt, byte_cnt+1; else pulse err_overflow, byte dropped, byte_cnt unchanged; bit_cnt=0 either way.
REQ-024 rx_valid SHALL assert exactly one cycle after the cycle in which the falling edge is detected on din_s (3 clk_20M after din pin fall, worst case 4).
REQ-025 rx_data, rx_index, frame_bytes SHALL hold last value between strobes.
REQ-026 All strobes SHALL be registered; at most one error strobe per cycle.
REQ-027 Back-to-back bits with low time of 1 cycle SHALL decode correctly.

Reset
REQ-028 rst high SHALL force state SYNC, all counters 0, synchronizer flops 0, rx_data=0, rx_index=0, frame_bytes=0, all strobes 0, asynchronously.
REQ-029 After rst release the block SHALL ignore din until a full T_RESET low gap is seen, so reset mid-frame never emits bytes from the truncated frame.

Verification
REQ-030 Reset, 1000 low cycles, bytes 0xA5,0x3C (bit=1: 16 high/9 low; bit=0: 8 high/17 low), 1000 low -> rx_valid twice: 0xA5 idx 0, 0x3C idx 1; frame_done once, frame_bytes=2.
REQ-031 Boundary widths: highs of 11 and 12 cycles -> bits 0 and 1 respectively; high of 2 cycles -> err_glitch, no bit counted.
REQ-032 49 bytes in one frame -> 48 rx_valid (idx 0..47), err_overflow once, frame_bytes=48.
REQ-033 5 bits then 1000 low -> err_partial once, no rx_valid, no frame_done.
REQ-034 din high 40 cycles mid-byte -> err_long; subsequent bytes ignored until 1000-cycle low gap, then decode resumes at idx 0.
REQ-035 Assert rst during byte 3, release, continue stream -> no rx_valid until after next full latch gap.
